// File: rtl/rover_move_executor_pkg.sv
// rover_move_executor_pkg
// Shared definitions for the rover move executor: move-command field
// positions, the largest legal turn count, FSM state encodings (4 bits wide
// so they line up with the main-FPGA path FSM) and small field helpers.
package rover_move_executor_pkg;

   localparam int CMD_W    = 12;
   localparam int TURN_MSB = 11;
   localparam int TURN_LSB = 8;
   localparam int FWD_MSB  = 7;
   localparam int FWD_LSB  = 0;
   localparam int MAX_TURN = 11;
   localparam int UNIT_W   = 8;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_TURN    = 4'd1,
      ST_DEAD    = 4'd2,
      ST_FORWARD = 4'd3,
      ST_DONE    = 4'd4
   } state_t;

   function automatic logic [3:0] cmd_turn(input logic [CMD_W-1:0] cmd);
      return cmd[TURN_MSB:TURN_LSB];
   endfunction

   function automatic logic [UNIT_W-1:0] cmd_fwd(input logic [CMD_W-1:0] cmd);
      return cmd[FWD_MSB:FWD_LSB];
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rover_move_executor_phase_timer.sv
// rover_move_executor_phase_timer
// Times one motion phase of i_units x i_cycles clock cycles without a
// multiplier: a prescaler runs 0..(i_cycles-1) and a step counter counts the
// units down to zero. o_expire is high during the final cycle of the phase.
// A load restarts the timer; when the step counter reaches 0 it stays idle.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   i_load           load a new phase (takes effect at this edge)
//   i_units          number of units in the phase (must be > 0)
//   i_cycles         cycles per unit (must be > 0)
//   o_expire         high in the last cycle of the loaded phase
module rover_move_executor_phase_timer
   import rover_move_executor_pkg::*;
#(
   parameter int W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic [UNIT_W-1:0] i_units,
   input  logic [W-1:0]      i_cycles,
   output logic              o_expire
);

   localparam logic [W-1:0]      ONE_W = W'(1);
   localparam logic [UNIT_W-1:0] ONE_U = UNIT_W'(1);

   logic [W-1:0]      r_presc;
   logic [W-1:0]      r_limit;
   logic [UNIT_W-1:0] r_units;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_presc <= '0;
         r_limit <= '0;
         r_units <= '0;
      end else if (i_load) begin
         r_presc <= '0;
         r_limit <= i_cycles - ONE_W;
         r_units <= i_units;
      end else if (r_units != '0) begin
         if (r_presc == r_limit) begin
            r_presc <= '0;
            r_units <= r_units - ONE_U;
         end else begin
            r_presc <= r_presc + ONE_W;
         end
      end
   end

   // r_units == 1 also implies the timer is active.
   assign o_expire = (r_units == ONE_U) && (r_presc == r_limit);

endmodule

// File: rtl/rover_move_executor.sv
// rover_move_executor
// Decodes a 12-bit move command into a clockwise turn followed by a straight
// forward run, drives the H-bridge controls for exact durations with an
// all-off dead band between turn and forward, and reports completion.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   cmd_valid           command strobe, only looked at while cmd_ready
//   move_command[11:0]  [11:8] clockwise 30-degree steps, [7:0] forward units
//   cmd_ready           high in IDLE
//   busy                high in TURN, DEAD, FORWARD, DONE
//   done                one-cycle completion pulse
//   cmd_error           one-cycle pulse for a turn field of 12..15
//   left_fwd, left_rev, right_fwd, right_rev   registered motor drives
//
// state   | meaning
// IDLE    | waiting for a command, motors off
// TURN    | spinning clockwise: left_fwd + right_rev
// DEAD    | all motors off before the right wheel reverses direction
// FORWARD | driving straight: left_fwd + right_fwd
// DONE    | one-cycle completion pulse, motors off
module rover_move_executor
   import rover_move_executor_pkg::*;
#(
   parameter int TURN_CYCLES = 2_700_000,
   parameter int FWD_CYCLES  = 1_350_000,
   parameter int DEAD_CYCLES = 270_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [CMD_W-1:0] move_command,
   output logic             cmd_ready,
   output logic             busy,
   output logic             done,
   output logic             cmd_error,
   output logic             left_fwd,
   output logic             left_rev,
   output logic             right_fwd,
   output logic             right_rev
);

   localparam int PRESC_W = $clog2(max3(TURN_CYCLES, FWD_CYCLES, DEAD_CYCLES) + 1);
   localparam logic [PRESC_W-1:0] TURN_LD = PRESC_W'(TURN_CYCLES);
   localparam logic [PRESC_W-1:0] FWD_LD  = PRESC_W'(FWD_CYCLES);
   localparam logic [PRESC_W-1:0] DEAD_LD = PRESC_W'(DEAD_CYCLES);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_turn;
   logic [UNIT_W-1:0] r_fwd;
   logic              r_cmd_error;
   logic              r_left_fwd;
   logic              r_left_rev;
   logic              r_right_fwd;
   logic              r_right_rev;

   logic [3:0]         w_cmd_turn;
   logic [UNIT_W-1:0]  w_cmd_fwd;
   logic               w_accept;
   logic               w_err;
   logic               w_load;
   logic [UNIT_W-1:0]  w_units;
   logic [PRESC_W-1:0] w_cycles;
   logic               w_expire;

   assign w_cmd_turn = cmd_turn(move_command);
   assign w_cmd_fwd  = cmd_fwd(move_command);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_turn      <= '0;
         r_fwd       <= '0;
         r_cmd_error <= 1'b0;
         r_left_fwd  <= 1'b0;
         r_left_rev  <= 1'b0;
         r_right_fwd <= 1'b0;
         r_right_rev <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cmd_error <= w_err;
         if (w_accept) begin
            r_turn <= w_cmd_turn;
            r_fwd  <= w_cmd_fwd;
         end
         // Drives follow the state being entered so the first phase cycle
         // already shows its pattern; DEAD separates right_fwd from right_rev.
         r_left_fwd  <= (w_next == ST_TURN) || (w_next == ST_FORWARD);
         r_left_rev  <= 1'b0;
         r_right_fwd <= (w_next == ST_FORWARD);
         r_right_rev <= (w_next == ST_TURN);
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_err    = 1'b0;
      w_load   = 1'b0;
      w_units  = '0;
      w_cycles = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (w_cmd_turn > 4'(MAX_TURN)) begin
                  w_err = 1'b1;
               end else begin
                  w_accept = 1'b1;
                  if (w_cmd_turn != '0) begin
                     w_next   = ST_TURN;
                     w_load   = 1'b1;
                     w_units  = {4'b0, w_cmd_turn};
                     w_cycles = TURN_LD;
                  end else if (w_cmd_fwd != '0) begin
                     w_next   = ST_FORWARD;
                     w_load   = 1'b1;
                     w_units  = w_cmd_fwd;
                     w_cycles = FWD_LD;
                  end else begin
                     w_next = ST_DONE;
                  end
               end
            end
         end
         ST_TURN: begin
            if (w_expire) begin
               if (r_fwd != '0) begin
                  w_next   = ST_DEAD;
                  w_load   = 1'b1;
                  w_units  = UNIT_W'(1);
                  w_cycles = DEAD_LD;
               end else begin
                  w_next = ST_DONE;
               end
            end
         end
         ST_DEAD: begin
            if (w_expire) begin
               w_next   = ST_FORWARD;
               w_load   = 1'b1;
               w_units  = r_fwd;
               w_cycles = FWD_LD;
            end
         end
         ST_FORWARD: begin
            if (w_expire) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   rover_move_executor_phase_timer #(
      .W (PRESC_W)
   ) u_phase_timer (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_load),
      .i_units  (w_units),
      .i_cycles (w_cycles),
      .o_expire (w_expire)
   );

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign cmd_error = r_cmd_error;
   assign left_fwd  = r_left_fwd;
   assign left_rev  = r_left_rev;
   assign right_fwd = r_right_fwd;
   assign right_rev = r_right_rev;

endmodule

// File: doc/rover_move_executor.md
# rover_move_executor

Rover-side consumer of the 12-bit move command issued by the main-FPGA orientation/path logic. It decodes each command into a clockwise turn followed by a straight forward run. It drives the four H-bridge motor controls for exactly timed durations, inserts a dead band before direction reversal, and reports completion back to the command source.

## Interface
Parameters:
- TURN_CYCLES, 2_700_000: clock cycles per turn step (one step = 30°).
- FWD_CYCLES, 1_350_000: clock cycles per forward distance unit.
- DEAD_CYCLES, 270_000: all-motors-off cycles between the turn phase and the forward phase.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command strobe; sampled only while cmd_ready=1.
- move_command  in  12  [11:8] turn steps clockwise (0–11 legal); [7:0] forward units.
- cmd_ready  out  1  high only in IDLE.
- busy  out  1  high in TURN, DEAD, FORWARD and DONE.
- done  out  1  one-cycle pulse at command completion.
- cmd_error  out  1  one-cycle pulse when an illegal turn field (12–15) is offered.
- left_fwd, left_rev, right_fwd, right_rev  out  1 each  motor drive; registered.

## Operation
- States: IDLE, TURN, DEAD, FORWARD, DONE.
- IDLE: if cmd_valid=1, latch turn=move_command[11:8] and fwd=move_command[7:0].
  - turn>11: pulse cmd_error, stay in IDLE, no motion.
  - turn>0: go to TURN.
  - turn=0 and fwd>0: go to FORWARD.
  - turn=0 and fwd=0: go to DONE.
- TURN: left_fwd=1 and right_rev=1, all other motor outputs 0, for turn×TURN_CYCLES cycles.
  - Then go to DEAD if fwd>0, else go to DONE.
- DEAD: all motor outputs 0 for DEAD_CYCLES cycles, then go to FORWARD.
- FORWARD: left_fwd=1 and right_fwd=1 for fwd×FWD_CYCLES cycles, then go to DONE.
- DONE: all motor outputs 0 and done=1 for one cycle, then go to IDLE.
- Timing arithmetic:
  - A cycle prescaler counts 0..(phase cycles−1).
  - A step counter counts latched units down to 0.
  - No multiplier is used.
  - The prescaler is wide enough for the largest parameter.
  - The step counter is 8 bits.
- cmd_valid while busy is ignored, with no queueing and no error. The latched command is never altered mid-execution.
- Motor outputs never assert a fwd and rev pair on the same wheel. The forward-then-reverse transition on the right wheel always passes through DEAD.
- Reset values: state IDLE; all motor outputs 0; done=0; cmd_error=0; busy=0; cmd_ready=1; counters 0.
- Reset mid-operation: motors are off at the next edge and the command is discarded. done is not pulsed.

## Timing
- Acceptance edge N is the first edge where cmd_valid=1 in IDLE. Motor outputs for the first phase are valid from cycle N+1.
- Phase lengths are exact: TURN = turn×TURN_CYCLES, DEAD = DEAD_CYCLES, FORWARD = fwd×FWD_CYCLES.
- The DONE cycle immediately follows the last phase cycle. cmd_ready returns in the cycle after DONE.
- Total latency from acceptance to done, where done appears in cycle N+1+L:
  - L = turn×TURN_CYCLES + (DEAD_CYCLES if turn>0 and fwd>0) + fwd×FWD_CYCLES.
- cmd_error is asserted in cycle N+1. cmd_ready stays high throughout.
- A new command may be accepted on the first cycle cmd_ready=1 again. There is no back-to-back acceptance in the DONE cycle.

## Structure
- Shared package:
  - Command field positions: TURN_MSB/LSB=11/8, FWD_MSB/LSB=7/0.
  - MAX_TURN=11.
  - State encodings, 4-bit to match the main-FPGA FSM width.
- One sub-module, phase_timer: loads (units, cycles_per_unit) and asserts expire on the final cycle. It is instantiated once and reloaded per phase.

## Test plan
Bench parameters: TURN_CYCLES=4, FWD_CYCLES=3, DEAD_CYCLES=2.
- Command 0x005 → left_fwd and right_fwd high for exactly 15 cycles from N+1. done pulses at N+16. No TURN or DEAD phase.
- Command 0x302 → TURN for 12 cycles (left_fwd, right_rev), DEAD for 2 cycles (all 0), FORWARD for 6 cycles. done pulses at N+21.
- Command 0x000 → no motor activity. done pulses at N+1. cmd_ready is 1 again at N+2.
- Command 0xC10 → cmd_error pulses at N+1. No motion, busy stays 0, and a legal 0x001 accepted next completes normally.
- Command 0x104 followed by 0x0FF pulsed during TURN → second command ignored. done pulses at N+4+2+12+1 = N+19.
- Reset asserted in the 3rd FORWARD cycle of 0x005 → all motors 0 and cmd_ready=1 at the next edge. No done pulse.
